instr_fifo_pair: RTL

INSTR_FIFO_PAIR -- requirements
Module: instr_fifo_pair

---
 rtl/instr_fifo_pair.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fifo_pair.sv
// Pair of first-word-fall-through instruction FIFOs fed from one arbiter output.
// Define FIFO_ERR_STICKY_EN to add sticky drop/conflict error flags.

module instr_fifo_lane #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_req,
    input  logic [WIDTH-1:0]         din,
    input  logic                     ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;

    // Push qualification uses the pre-pop count, so a full FIFO drops even while popping.
    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign do_push = push_req && !full;
    assign do_pop  = valid && ready;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[wp] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end
endmodule

module instr_fifo_pair #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       instr,
    input  logic                   FIFO_1_en,
    input  logic                   FIFO_2_en,
    output logic [WIDTH-1:0]       lane1_instr,
    output logic                   lane1_valid,
    input  logic                   lane1_ready,
    output logic [WIDTH-1:0]       lane2_instr,
    output logic                   lane2_valid,
    input  logic                   lane2_ready,
    output logic                   fifo1_full,
    output logic                   fifo2_full,
    output logic [$clog2(DEPTH):0] fifo1_count,
    output logic [$clog2(DEPTH):0] fifo2_count,
    output logic                   fifo1_err,
    output logic                   fifo2_err
);
    localparam int NUM_LANES = 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic [NUM_LANES-1:0]            push_req, lane_ready, lane_valid, lane_full;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane_instr;
    logic [NUM_LANES-1:0][CW-1:0]    lane_count;

    // FIFO 1 wins when both enables are raised.
    assign push_req   = {FIFO_2_en & ~FIFO_1_en, FIFO_1_en};
    assign lane_ready = {lane2_ready, lane1_ready};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        instr_fifo_lane #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .push_req (push_req[g]),
            .din      (instr),
            .ready    (lane_ready[g]),
            .dout     (lane_instr[g]),
            .valid    (lane_valid[g]),
            .full     (lane_full[g]),
            .count    (lane_count[g])
        );
    end

    assign lane1_instr = lane_instr[0];
    assign lane2_instr = lane_instr[1];
    assign lane1_valid = lane_valid[0];
    assign lane2_valid = lane_valid[1];
    assign fifo1_full  = lane_full[0];
    assign fifo2_full  = lane_full[1];
    assign fifo1_count = lane_count[0];
    assign fifo2_count = lane_count[1];

`ifdef FIFO_ERR_STICKY_EN
    logic [NUM_LANES-1:0] err_q;
    logic                 conflict;

    assign conflict = FIFO_1_en & FIFO_2_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= '0;
        else
            err_q <= err_q | (push_req & lane_full) | {conflict, 1'b0};
    end

    assign fifo1_err = err_q[0];
    assign fifo2_err = err_q[1];
`else
    assign fifo1_err = 1'b0;
    assign fifo2_err = 1'b0;
`endif
endmodule
